// File: rtl/riscv_muldiv_unit.sv
// RV32M multiply/divide execute unit: single-cycle multiply, 32-step restoring divider.
// Optional RISCV_MULDIV_EARLY_OUT_EN: divides with |dividend| < |divisor| finish on the fast path.
module riscv_muldiv_unit #(
   parameter int XLEN       = 32,
   parameter int DIV_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_addr,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      w_addr,
   output logic            w_en
);

   typedef enum logic [1:0] {S_IDLE, S_FAST, S_DIV, S_DONE} state_t;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state_q, state_d;
   logic [2:0]      f_q, f_d;
   logic [XLEN-1:0] a_q, a_d;      // dividend, then shifted quotient during DIV
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [4:0]      rd_q, rd_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            prep_q, prep_d;
   logic            negq_q, negq_d;
   logic            negr_q, negr_d;
   logic [XLEN-1:0] res_q, res_d;
   logic [4:0]      waddr_q, waddr_d;

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? -v : v;
   endfunction

   logic            ovf_in, early_in, sgn_q, ovf_q;
   logic signed [63:0] mul_a, mul_b, prod;
   logic [XLEN-1:0] fast_res, q_n, rem_n;
   logic [XLEN:0]   rem_sh, diff;
   logic            qbit;

   assign ovf_in = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
`ifdef RISCV_MULDIV_EARLY_OUT_EN
   assign early_in = funct3[2] && (op_b != '0) &&
                     (mag(op_a, !funct3[0]) < mag(op_b, !funct3[0]));
`else
   assign early_in = 1'b0;
`endif

   assign sgn_q = !f_q[0];
   assign ovf_q = sgn_q && (a_q == MIN_NEG) && (b_q == '1);

   // Fast path: full 64-bit product of sign/zero-extended operands, or a special-case divide
   always_comb begin
      mul_a    = $signed({{32{(f_q == 3'd1 || f_q == 3'd2) && a_q[XLEN-1]}}, a_q});
      mul_b    = $signed({{32{(f_q == 3'd1) && b_q[XLEN-1]}}, b_q});
      prod     = mul_a * mul_b;
      fast_res = '0;
      if (!f_q[2])
         fast_res = (f_q == 3'd0) ? prod[31:0] : prod[63:32];
      else if (b_q == '0)
         fast_res = f_q[1] ? a_q : '1;
      else if (ovf_q)
         fast_res = f_q[1] ? '0 : MIN_NEG;
      else
         fast_res = f_q[1] ? a_q : '0;
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      rem_sh = {rem_q, a_q[XLEN-1]};
      diff   = rem_sh - {1'b0, b_q};
      qbit   = !diff[XLEN];
      rem_n  = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      q_n    = {a_q[XLEN-2:0], qbit};
   end

   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      prep_d  = prep_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      res_d   = res_q;
      waddr_d = waddr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               f_d    = funct3;
               a_d    = op_a;
               b_d    = op_b;
               rd_d   = rd_addr;
               cnt_d  = '0;
               rem_d  = '0;
               prep_d = 1'b1;
               if (!funct3[2] || (op_b == '0) || ovf_in || early_in)
                  state_d = S_FAST;
               else
                  state_d = S_DIV;
            end
         end
         S_FAST: begin
            res_d   = fast_res;
            waddr_d = rd_q;
            state_d = S_DONE;
         end
         S_DIV: begin
            if (prep_q) begin
               // first DIV cycle converts to magnitudes and records result signs
               a_d    = mag(a_q, sgn_q);
               b_d    = mag(b_q, sgn_q);
               negq_d = sgn_q && (a_q[XLEN-1] ^ b_q[XLEN-1]);
               negr_d = sgn_q && a_q[XLEN-1];
               rem_d  = '0;
               prep_d = 1'b0;
            end else begin
               a_d   = q_n;
               rem_d = rem_n;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'(DIV_CYCLES-1)) begin
                  if (f_q[1])
                     res_d = negr_q ? -rem_n : rem_n;
                  else
                     res_d = negq_q ? -q_n : q_n;
                  waddr_d = rd_q;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         f_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         prep_q  <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         res_q   <= '0;
         waddr_q <= '0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         prep_q  <= prep_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         res_q   <= res_d;
         waddr_q <= waddr_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign w_en   = done;
   assign result = res_q;
   assign w_addr = waddr_q;

endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
- Multi-cycle RV32M execute unit, directly downstream of the register bank.
- Consumes the two read-port operands, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, and produces the write-back triple (data, address, enable) that drives the register bank write port.
- Control holds the instruction stable and stalls the PC while busy is high.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- DIV_CYCLES, 32, iterations of the restoring divider; must equal XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- funct3  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- op_a  input  XLEN  rs1 value (register bank rd_a)
- op_b  input  XLEN  rs2 value (register bank rd_b)
- rd_addr  input  5  destination register
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  write-back data (to w_data)
- w_addr  output  5  write-back register (to r_write)
- w_en  output  1  equals done (to w_en)

Behaviour:
- Reset: synchronous, active-high; clock is clk, reset is rst. When rst is high at a rising edge: state goes to IDLE; busy, done, w_en, result, w_addr and all internal registers go to 0. Reset during any state aborts the operation with no done pulse.
- States: IDLE, FAST, DIV, DONE.
- IDLE:
  - start=1 latches funct3, op_a, op_b and rd_addr.
  - funct3<4 goes to FAST.
  - Divide by zero or signed overflow goes to FAST.
  - Any other divide goes to DIV.
  - start=0 stays in IDLE.
- Start while busy: ignored; it is not queued.
- FAST: computes the result and registers it, then goes to DONE.
- DIV: restoring division on magnitudes, one quotient bit per cycle. A 5-bit counter runs from 0 to DIV_CYCLES-1; at the last count the state goes to DONE.
- DONE: done=1 and w_en=1 for exactly one cycle, then IDLE. A new start is accepted from the following IDLE cycle.
- Latency, with cycle 0 as the IDLE cycle where start=1 is sampled:
  - Multiplies and fast-path divides: done in cycle 2.
  - Iterative divides: done in cycle 34.
- result and w_addr hold their last value after done until the next DONE.
- Multiply: full 64-bit product of 33-bit sign/zero-extended operands.
  - MUL returns the low 32 bits.
  - MULH: signed x signed, upper 32 bits.
  - MULHSU: signed op_a x unsigned op_b, upper 32 bits.
  - MULHU: unsigned x unsigned, upper 32 bits.
- Signed divide: operands are converted to magnitudes on entry.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (op_b=0):
  - DIV/DIVU quotient = 0xFFFF_FFFF.
  - REM/REMU remainder = op_a.
- Signed overflow (DIV/REM with op_a=0x8000_0000, op_b=0xFFFF_FFFF): quotient = 0x8000_0000, remainder = 0.
- rd_addr=0 is passed through unchanged; the register bank ignores writes to x0.
- Inputs are not required to stay stable after the start cycle.

Optional Feature:
- Macro: RISCV_MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, a divide with |dividend| < |divisor| (magnitudes per signedness) goes to FAST. The result is quotient 0 and remainder = op_a, with done in cycle 2.
- Undefined: such divides take the full DIV path (done in cycle 34) with an identical result.

Test Plan:
- Reset, then MUL with op_a=0x0000_0007, op_b=0xFFFF_FFFD, rd_addr=5 -> cycle 2: done=1, w_en=1, result=0xFFFF_FFEB, w_addr=5; busy high in cycles 1-2, low in cycle 3.
- MULH 0x8000_0000 x 0x8000_0000 -> 0x4000_0000; MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE; MULHSU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFF.
- DIV -20/3 -> 0xFFFF_FFFA in cycle 34; REM -20/3 -> 0xFFFF_FFFE; DIVU 0xFFFF_FFFF/0x10 -> 0x0FFF_FFFF.
- DIVU 0x1234/0 -> 0xFFFF_FFFF, REMU -> 0x1234, DIV 0x8000_0000/-1 -> 0x8000_0000; each with done in cycle 2.
- Start held high during a DIV -> ignored, exactly one done. Assert rst in cycle 10 of a DIV -> no done; busy=0, result=0 the next cycle; a new MUL afterwards completes normally.
- DIVU 5/9 -> quotient 0 with done in cycle 2 if RISCV_MULDIV_EARLY_OUT_EN is defined, cycle 34 otherwise.
